amds_rx_sequencer: RTL and testbench

Packet-level controller for one AMDS sensor UART link. It sits between the PWM/sample trigger logic and a single byte receiver. On each trigger it waits a programmable delay, then arms the receiver once per expected byte and collects NUM_BYTES bytes into a shadow buffer. The packet is committed atomically to the AXI-visible data register only if every byte arrives intact. Timeouts, parity failures and trigger overruns are counted.

---
 rtl/amds_rx_sequencer.sv | 152 +++++++++++++++
 tb/tb_amds_rx_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amds_rx_sequencer.sv
// Packet controller for one AMDS sensor UART link: delays after a trigger, arms the
// byte receiver once per byte, and commits the packet atomically only if all bytes arrive.
module amds_rx_sequencer #(
    parameter int NUM_BYTES = 8,
    parameter int WDOG_MAX  = 4095
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   trigger,
    input  logic [15:0]            delay_cycles,
    input  logic                   clear_counters,
    output logic                   rx_start,
    input  logic                   rx_byte_valid,
    input  logic                   rx_data_corrupt,
    input  logic                   rx_timeout,
    input  logic [7:0]             rx_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   pkt_ok,
    output logic [8*NUM_BYTES-1:0] data,
    output logic                   data_valid,
    output logic [15:0]            cnt_timeout,
    output logic [15:0]            cnt_corrupt,
    output logic [15:0]            cnt_overrun
);
    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam int WD_W  = $clog2(WDOG_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WDOG_MAX);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_ARM, S_WAIT, S_COMMIT, S_ABORT} state_t;

    state_t                        state;
    logic [15:0]                   dly;
    logic [IDX_W-1:0]              idx;
    logic [WD_W-1:0]               wd;
    logic [NUM_BYTES-1:0][7:0]     shadow;
    logic [NUM_BYTES-1:0][7:0]     data_q;

    assign data = data_q;

    // Flag priority in WAIT: timeout, then corrupt, then good byte, then watchdog.
    logic inc_to, inc_co, inc_ov;
    always_comb begin
        inc_to = (state == S_WAIT) &&
                 (rx_timeout || (!rx_data_corrupt && !rx_byte_valid && wd == WD_LIMIT));
        inc_co = (state == S_WAIT) && !rx_timeout && rx_data_corrupt;
        inc_ov = trigger && (state != S_IDLE);
    end

    function automatic logic [15:0] bump(input logic [15:0] c, input logic inc, input logic clr);
        if (clr) return 16'h0000;
        if (inc && c != 16'hFFFF) return c + 16'h0001;
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_timeout <= '0;
            cnt_corrupt <= '0;
            cnt_overrun <= '0;
        end else begin
            cnt_timeout <= bump(cnt_timeout, inc_to, clear_counters);
            cnt_corrupt <= bump(cnt_corrupt, inc_co, clear_counters);
            cnt_overrun <= bump(cnt_overrun, inc_ov, clear_counters);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dly        <= '0;
            idx        <= '0;
            wd         <= '0;
            shadow     <= '0;
            data_q     <= '0;
            data_valid <= 1'b0;
            rx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pkt_ok     <= 1'b0;
        end else begin
            rx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger && enable) begin
                        dly   <= delay_cycles;
                        idx   <= '0;
                        wd    <= '0;
                        busy  <= 1'b1;
                        state <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (dly == 16'h0000) begin
                        rx_start <= 1'b1;
                        state    <= S_ARM;
                    end else begin
                        dly <= dly - 16'h0001;
                    end
                end
                S_ARM: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rx_timeout || rx_data_corrupt) begin
                        done   <= 1'b1;
                        pkt_ok <= 1'b0;
                        state  <= S_ABORT;
                    end else if (rx_byte_valid) begin
                        shadow[idx] <= rx_dout;
                        if (idx == IDX_LAST) begin
                            done   <= 1'b1;
                            pkt_ok <= 1'b1;
                            state  <= S_COMMIT;
                        end else begin
                            idx      <= idx + IDX_ONE;
                            rx_start <= 1'b1;
                            state    <= S_ARM;
                        end
                    end else if (wd == WD_LIMIT) begin
                        done   <= 1'b1;
                        pkt_ok <= 1'b0;
                        state  <= S_ABORT;
                    end else begin
                        wd <= wd + WD_ONE;
                    end
                end
                // Whole packet lands in the visible register on a single edge.
                S_COMMIT: begin
                    data_q     <= shadow;
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                S_ABORT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_amds_rx_sequencer.sv
// Bench for amds_rx_sequencer: a behavioural byte receiver answers each arm pulse from a
// per-byte plan; packet outcome, timing and counters are predicted from the plan arithmetically.
module tb_amds_rx_sequencer;
    localparam int N    = 8;
    localparam int WDOG = 4095;

    logic             clk = 1'b0, rst_n = 1'b0, enable = 1'b0, trigger = 1'b0, clear_counters = 1'b0;
    logic [15:0]      delay_cycles = '0;
    logic             rx_start, busy, done, pkt_ok, data_valid;
    logic             rbv = 1'b0, rco = 1'b0, rto = 1'b0;
    logic [7:0]       rdout = '0;
    logic [8*N-1:0]   data;
    logic [15:0]      cnt_timeout, cnt_corrupt, cnt_overrun;

    amds_rx_sequencer #(.NUM_BYTES(N), .WDOG_MAX(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
        .delay_cycles(delay_cycles), .clear_counters(clear_counters),
        .rx_start(rx_start), .rx_byte_valid(rbv), .rx_data_corrupt(rco),
        .rx_timeout(rto), .rx_dout(rdout), .busy(busy), .done(done), .pkt_ok(pkt_ok),
        .data(data), .data_valid(data_valid), .cnt_timeout(cnt_timeout),
        .cnt_corrupt(cnt_corrupt), .cnt_overrun(cnt_overrun));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte plan: kind 0 good, 1 parity fail, 2 receiver timeout, 3 silent (no flag ever)
    int         kind [16];
    logic [7:0] bval [16];
    int         lat  [16];
    int         pkt_base = 0, start_cnt = 0, rcnt = 0, ridx = 0;
    int         start_at [1024];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbv <= 1'b0; rco <= 1'b0; rto <= 1'b0; rcnt <= 0;
        end else if (rx_start) begin
            rbv <= 1'b0; rco <= 1'b0; rto <= 1'b0;
            ridx <= (start_cnt - pkt_base) & 15;
            rcnt <= lat[(start_cnt - pkt_base) & 15];
            start_at[start_cnt % 1024] <= cyc;
            start_cnt <= start_cnt + 1;
        end else if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) begin
                case (kind[ridx])
                    0: begin rbv <= 1'b1; rdout <= bval[ridx]; end
                    1: rco <= 1'b1;
                    2: rto <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    int             errors = 0, checks = 0;
    logic [8*N-1:0] exp_data = '0;
    logic           exp_dv = 1'b0, exp_ok = 1'b0;
    int             exp_to = 0, exp_co = 0, exp_ov = 0;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_data"},  64'(data), 64'(exp_data));
        chk({tag, "_dv"},    64'(data_valid), 64'(exp_dv));
        chk({tag, "_pktok"}, 64'(pkt_ok), 64'(exp_ok));
        chk({tag, "_cto"},   64'(cnt_timeout), 64'(exp_to));
        chk({tag, "_cco"},   64'(cnt_corrupt), 64'(exp_co));
        chk({tag, "_cov"},   64'(cnt_overrun), 64'(exp_ov));
    endtask

    task automatic plan_good(input int lo, input int hi);
        for (int i = 0; i < 16; i++) begin
            kind[i] = 0;
            bval[i] = 8'($urandom);
            lat[i]  = $urandom_range(hi, lo);
        end
    endtask

    // Trigger a packet, optionally inject one overrun trigger at period T+ov_at,
    // then compare against the outcome derived from the byte plan.
    task automatic run_packet(input string tag, input int d, input int ov_at, input bit en_after);
        int T, s, exp_done, n_arm, dc;
        bit stop, got;
        pkt_base = start_cnt;
        T = cyc;
        enable = 1'b1; delay_cycles = 16'(d); trigger = 1'b1;
        tick();
        trigger = 1'b0; enable = en_after;
        chk({tag, "_busy_rise"}, 64'(busy), 64'(1));

        s = T + 2 + d; n_arm = 0; stop = 0; exp_done = 0;
        for (int i = 0; i < N && !stop; i++) begin
            n_arm++;
            case (kind[i])
                0: if (i == N - 1) exp_done = s + 2 + lat[i];
                   else s = s + 2 + lat[i];
                1: begin exp_done = s + 2 + lat[i]; exp_co = sat(exp_co + 1); stop = 1; end
                2: begin exp_done = s + 2 + lat[i]; exp_to = sat(exp_to + 1); stop = 1; end
                default: begin exp_done = s + 2 + WDOG; exp_to = sat(exp_to + 1); stop = 1; end
            endcase
        end
        if (ov_at > 0) exp_ov = sat(exp_ov + 1);
        exp_ok = !stop;
        if (!stop) begin
            for (int i = 0; i < N; i++) exp_data[8*i +: 8] = bval[i];
            exp_dv = 1'b1;
        end

        got = 0; dc = 0;
        for (int n = 0; n < WDOG + 300; n++) begin
            if (done) begin got = 1; dc = cyc; break; end
            trigger = (ov_at > 0 && cyc == T + ov_at);
            tick();
        end
        trigger = 1'b0; enable = 1'b1;
        chk({tag, "_done_seen"}, 64'(got), 64'(1));
        if (got) begin
            chk({tag, "_done_cyc"},  64'(dc - T), 64'(exp_done - T));
            chk({tag, "_done_ok"},   64'(pkt_ok), 64'(exp_ok));
            chk({tag, "_arms"},      64'(start_cnt - pkt_base), 64'(n_arm));
            chk({tag, "_first_arm"}, 64'(start_at[pkt_base % 1024] - T), 64'(2 + d));
            tick();
            chk({tag, "_done_pulse"}, 64'(done), 64'(0));
            check_status(tag);
        end
    endtask

    task automatic reset_check(input string tag);
        exp_data = '0; exp_dv = 0; exp_ok = 0; exp_to = 0; exp_co = 0; exp_ov = 0;
        chk({tag, "_rxstart"}, 64'(rx_start), 64'(0));
        chk({tag, "_done"},    64'(done), 64'(0));
        check_status(tag);
    endtask

    initial begin
        int T;
        bit got;
        plan_good(1, 1);
        #1;
        reset_check("por");
        tick(); rst_n = 1'b1; tick();

        // Directed packet 0x01..0x08
        plan_good(2, 2);
        for (int i = 0; i < N; i++) bval[i] = 8'(i + 1);
        run_packet("tp_good", 10, 0, 1);
        chk("tp_good_const", 64'(data), 64'h0807060504030201);

        // Third byte parity failure: data keeps previous packet
        plan_good(1, 3); kind[2] = 1;
        run_packet("tp_corrupt", 3, 0, 1);

        // No sensor response, then stuck receiver (watchdog)
        plan_good(1, 2); kind[0] = 2;
        run_packet("tp_rxto", 0, 0, 1);
        plan_good(1, 2); kind[0] = 3;
        run_packet("tp_wdog", 2, 0, 1);

        // Trigger during WAIT, enable dropped mid-packet: packet still completes
        plan_good(2, 2); lat[0] = 20;
        run_packet("tp_ovr_wait", 4, 10, 0);

        // Trigger with enable low in IDLE: ignored, not counted
        T = start_cnt;
        enable = 1'b0; trigger = 1'b1; tick(); trigger = 1'b0; enable = 1'b1;
        chk("tp_dis_busy", 64'(busy), 64'(0));
        repeat (20) tick();
        chk("tp_dis_arms", 64'(start_cnt - T), 64'(0));
        check_status("tp_dis");

        // Randomized packets, back to back
        for (int r = 0; r < 8; r++) begin
            int e;
            plan_good(1, 4);
            e = $urandom_range(2 * N - 1, 0);
            if (e < N) kind[e] = $urandom_range(2, 1);
            run_packet("rand", $urandom_range(20, 0), 0, 1);
        end

        // Overrun saturation, then clear_counters on the same cycle as increments
        plan_good(3, 3); kind[0] = 1;
        pkt_base = start_cnt;
        enable = 1'b1; delay_cycles = 16'hFFFF; trigger = 1'b1;
        repeat (65540) tick();
        exp_ov = 65535;
        chk("sat_ovr", 64'(cnt_overrun), 64'(exp_ov));
        got = 0;
        for (int n = 0; n < 200; n++) begin
            if (rco) begin got = 1; break; end
            tick();
        end
        chk("sat_flag_seen", 64'(got), 64'(1));
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0; trigger = 1'b0;
        exp_to = 0; exp_co = 0; exp_ov = 0; exp_ok = 0;
        chk("sat_done", 64'(done), 64'(1));
        tick();
        check_status("sat_clr");

        // Reset during DELAY
        plan_good(2, 2);
        enable = 1'b1; delay_cycles = 16'd50; trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0; #1;
        reset_check("rst_delay");
        tick(); rst_n = 1'b1; tick();

        // Reset during WAIT
        plan_good(30, 30);
        delay_cycles = 16'd0; trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (5) tick();
        chk("rst_wait_busy", 64'(busy), 64'(1));
        rst_n = 1'b0; #1;
        reset_check("rst_wait");
        tick(); rst_n = 1'b1; tick();

        plan_good(1, 3);
        run_packet("post_rst", 7, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
